// File: rtl/im_loader_pkg.sv
// Shared instruction-memory map and loader FSM encoding.
// The IF stage and the loader both take the text segment bounds from here.
package im_loader_pkg;

  localparam logic [31:0] MEM_TEXT_START = 32'h0000_3000;
  localparam int          MEM_SIZE_WORD  = 4096;
  localparam logic [31:0] MEM_TEXT_END   = MEM_TEXT_START + 32'(4 * MEM_SIZE_WORD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_ADDR,
    ST_HDR_CNT,
    ST_CHECK,
    ST_PAYLOAD,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_t;

  // Header acceptance test. The end-address sum is widened to 35 bits so
  // no combination of a 32-bit address and a 32-bit word count can wrap.
  function automatic logic header_ok(input logic [31:0] a,
                                     input logic [31:0] n,
                                     input logic [31:0] base,
                                     input logic [34:0] limit);
    logic [34:0] end_addr;
    end_addr  = {3'b000, a} + {1'b0, n, 2'b00};
    header_ok = (a[1:0] == 2'b00) && (a >= base) && (n != 32'd0) &&
                (end_addr <= limit);
  endfunction

endpackage

// File: rtl/im_loader_byte_word_assembler.sv
// Big-endian byte-to-word assembler: first byte of a group lands in [31:24].
// word_next is the word including the byte currently presented.
module byte_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        last
);

  logic [1:0]  cnt;
  logic [23:0] sr;

  assign word_next = {sr, byte_in};
  assign last      = (cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= 2'd0;
      sr  <= 24'd0;
    end else if (shift) begin
      cnt <= cnt + 2'd1;
      sr  <= word_next[23:0];
    end
  end

endmodule

// File: rtl/im_loader.sv
// Boot loader: parses an address/count/payload byte frame and writes the
// payload into instruction memory, holding the core in reset until done.
module im_loader
  import im_loader_pkg::*;
#(
  parameter logic [31:0] TEXT_STARTADDR = MEM_TEXT_START,
  parameter int          IM_SIZE_WORD   = MEM_SIZE_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  localparam logic [34:0] LIMIT =
    {3'b000, TEXT_STARTADDR} + 35'(IM_SIZE_WORD) * 35'd4;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] cnt_q;
  logic [31:0] words_q;
  logic [31:0] waddr_q;
  logic [31:0] wdata_q;

  logic        idle_like;
  logic        start_go;
  logic        xfer;
  logic        asm_last;
  logic [31:0] asm_word;
  logic        last_word;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                     (state_q == ST_ERROR);
  assign start_go  = start && idle_like;
  assign rx_ready  = (state_q == ST_HDR_ADDR) || (state_q == ST_HDR_CNT) ||
                     (state_q == ST_PAYLOAD);
  assign xfer      = rx_valid && rx_ready;
  assign last_word = ((words_q + 32'd1) == cnt_q);

  byte_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_go),
    .shift     (xfer),
    .byte_in   (rx_data),
    .word_next (asm_word),
    .last      (asm_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_d = ST_HDR_ADDR;
      ST_HDR_ADDR: if (xfer && asm_last) state_d = ST_HDR_CNT;
      ST_HDR_CNT:  if (xfer && asm_last) state_d = ST_CHECK;
      ST_CHECK:
        state_d = header_ok(addr_q, cnt_q, TEXT_STARTADDR, LIMIT) ?
                  ST_PAYLOAD : ST_ERROR;
      ST_PAYLOAD:  if (xfer && asm_last) state_d = ST_WRITE;
      ST_WRITE:    state_d = last_word ? ST_DONE : ST_PAYLOAD;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Header fields, write address/data and progress counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= 32'd0;
      cnt_q   <= 32'd0;
      words_q <= 32'd0;
      waddr_q <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      if (start_go) words_q <= 32'd0;
      case (state_q)
        ST_HDR_ADDR: if (xfer && asm_last) addr_q <= asm_word;
        ST_HDR_CNT:  if (xfer && asm_last) cnt_q  <= asm_word;
        ST_CHECK:    waddr_q <= addr_q;
        ST_PAYLOAD:  if (xfer && asm_last) wdata_q <= asm_word;
        ST_WRITE: begin
          waddr_q <= waddr_q + 32'd4;
          words_q <= words_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign we       = (state_q == ST_WRITE);
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign busy     = !idle_like;
  assign done     = (state_q == ST_DONE);
  assign error    = (state_q == ST_ERROR);
  assign cpu_hold = (state_q != ST_DONE);

endmodule
